// File: rtl/collision_monitor.sv
// Bump-sensor collision monitor: per-channel debounce feeding a DRIVE/COLLIDE/RECOVER
// state machine that gates the motors and logs which channels caused each stop.
module collision_monitor #(
    parameter int N_SENS      = 2,
    parameter int ASSERT_CYC  = 50000,
    parameter int RELEASE_CYC = 50000,
    parameter int HOLD_CYC    = 50000,
    parameter int CNT_W       = 26,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SENS-1:0]  sens,
    input  logic [N_SENS-1:0]  en_mask,
    input  logic               clr_count,
    output logic               drive,
    output logic [2:0]         state_led,
    output logic [N_SENS-1:0]  deb,
    output logic [N_SENS-1:0]  col_ch,
    output logic [COUNT_W-1:0] col_count
);

    // One-hot encoding lets the state register itself serve as the registered LED output.
    typedef enum logic [2:0] {
        S_DRIVE   = 3'b001,
        S_COLLIDE = 3'b010,
        S_RECOVER = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] ASR_LAST  = CNT_W'(ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      hold_cnt;
    logic [CNT_W-1:0]      deb_cnt [N_SENS];
    logic [N_SENS-1:0]     raw;
    logic [N_SENS-1:0]     hit_vec;
    logic                  hit;
    logic                  entry;

    assign raw     = ~sens;
    assign hit_vec = deb & en_mask;
    assign hit     = |hit_vec;
    assign entry   = (state == S_DRIVE) && hit;

    // NOTE: these per-channel counters are ordinary flops, not a RAM, so every entry
    // is reset; all sequential state uses non-blocking assignments to avoid races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SENS; i++) deb_cnt[i] <= '0;
            deb <= '0;
        end else begin
            for (int i = 0; i < N_SENS; i++) begin
                if (raw[i] != deb[i]) begin
                    if (deb_cnt[i] == (deb[i] ? REL_LAST : ASR_LAST)) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RECOVER;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_DRIVE:   if (hit) state_nxt = S_COLLIDE;
            S_COLLIDE: if (!hit) state_nxt = S_RECOVER;
            S_RECOVER: begin
                if (hit)                       state_nxt = S_COLLIDE;
                else if (hold_cnt == HOLD_LAST) state_nxt = S_DRIVE;
            end
            default:   state_nxt = S_RECOVER;
        endcase
    end

    always_comb begin
        drive     = (state == S_DRIVE);
        state_led = state;
    end

    // Hold timer only advances across uninterrupted clear cycles in RECOVER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (state == S_RECOVER && !hit && hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + CNT_W'(1);
        else
            hold_cnt <= '0;
    end

    // Outside DRIVE entry hit_vec is zero whenever hit is low, so OR-ing is a hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_ch    <= '0;
            col_count <= '0;
        end else begin
            col_ch <= entry ? hit_vec : (col_ch | hit_vec);
            if (clr_count)
                col_count <= entry ? COUNT_W'(1) : '0;
            else if (entry && col_count != '1)
                col_count <= col_count + COUNT_W'(1);
        end
    end

endmodule
